// File: rtl/mesh_shuffle_sequencer.sv
// Valve/pump sequencer for an N_IN-input, DEPTH-stage diffusion-mixer mesh shuffle.
// A run loads the selected inlets, then mixes from stage DEPTH-1 down to 0, then drains; abort flushes.
module mesh_shuffle_sequencer #(
  parameter int N_IN         = 2,
  parameter int DEPTH        = 2,
  parameter int LOAD_CYCLES  = 3,
  parameter int MIX_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [N_IN-1:0]            in_mask,
  output logic [N_IN-1:0]            inlet_valve,
  output logic [DEPTH-1:0]           stage_en,
  output logic [N_IN-1:0]            outlet_valve,
  output logic [$clog2(DEPTH):0]     stage_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic                       err
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SW = $clog2(DEPTH) + 1;

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MIX,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_IN-1:0]   r_mask;
  logic [IW-1:0]     r_idx;
  logic [N_IN-1:0]   r_inlet;
  logic [DEPTH-1:0]  r_stage_en;
  logic [N_IN-1:0]   r_outlet;
  logic [SW-1:0]     r_stage_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic              r_err;

  logic [N_IN-1:0]   w_above;
  logic              w_more;
  logic [IW-1:0]     w_next_idx;
  logic [IW-1:0]     w_start_idx;
  logic              w_cnt_last;

  // Index of the lowest set bit; callers only use it when the vector is non-zero.
  function automatic logic [IW-1:0] lowest_idx(input logic [N_IN-1:0] v);
    lowest_idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IW'(i);
    end
  endfunction

  // Mask bits still waiting to be loaded: set bits strictly above the current inlet.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_above
      assign w_above[gi] = r_mask[gi] & (r_idx < IW'(gi));
    end
  endgenerate

  assign w_more      = |w_above;
  assign w_next_idx  = lowest_idx(w_above);
  assign w_start_idx = lowest_idx(in_mask);

  always_comb begin
    w_cnt_last = 1'b0;
    case (r_state)
      S_LOAD:           w_cnt_last = (r_cnt == LOAD_LAST);
      S_MIX:            w_cnt_last = (r_cnt == MIX_LAST);
      S_DRAIN, S_FLUSH: w_cnt_last = (r_cnt == DRAIN_LAST);
      default:          w_cnt_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_idx       <= '0;
      r_inlet     <= '0;
      r_stage_en  <= '0;
      r_outlet    <= '0;
      r_stage_idx <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (|in_mask) begin
              r_mask  <= in_mask;
              r_idx   <= w_start_idx;
              r_inlet <= N_IN'(1) << w_start_idx;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_LOAD, S_MIX, S_DRAIN: begin
          if (abort) begin
            // Close everything upstream and open every outlet to empty the mesh.
            r_inlet     <= '0;
            r_stage_en  <= '0;
            r_stage_idx <= '0;
            r_outlet    <= '1;
            r_cnt       <= '0;
            r_state     <= S_FLUSH;
          end else if (!w_cnt_last) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            case (r_state)
              S_LOAD: begin
                if (w_more) begin
                  r_idx   <= w_next_idx;
                  r_inlet <= N_IN'(1) << w_next_idx;
                end else begin
                  r_inlet     <= '0;
                  r_stage_en  <= DEPTH'(1) << (DEPTH - 1);
                  r_stage_idx <= SW'(DEPTH - 1);
                  r_state     <= S_MIX;
                end
              end
              S_MIX: begin
                if (r_stage_idx == '0) begin
                  r_stage_en <= '0;
                  r_outlet   <= r_mask;
                  r_state    <= S_DRAIN;
                end else begin
                  r_stage_en  <= r_stage_en >> 1;
                  r_stage_idx <= r_stage_idx - 1'b1;
                end
              end
              default: begin
                r_outlet <= '0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= S_IDLE;
              end
            endcase
          end
        end

        S_FLUSH: begin
          if (w_cnt_last) begin
            r_outlet  <= '0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign inlet_valve  = r_inlet;
  assign stage_en     = r_stage_en;
  assign outlet_valve = r_outlet;
  assign stage_idx    = r_stage_idx;
  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign err          = r_err;

endmodule

// File: tb/tb_mesh_shuffle_sequencer.sv
// Scoreboard bench for mesh_shuffle_sequencer: per-cycle expected output vectors are queued
// when a request is driven and compared one per clock against the DUT.
module tb_mesh_shuffle_sequencer;

  localparam int L = 3;
  localparam int M = 4;
  localparam int D = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [1:0] in_mask;
  logic [1:0] inlet_valve;
  logic [1:0] stage_en;
  logic [1:0] outlet_valve;
  logic [1:0] stage_idx;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       err;

  mesh_shuffle_sequencer #(
    .N_IN(2), .DEPTH(2), .LOAD_CYCLES(L), .MIX_CYCLES(M), .DRAIN_CYCLES(D), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_mask(in_mask),
    .inlet_valve(inlet_valve), .stage_en(stage_en), .outlet_valve(outlet_valve),
    .stage_idx(stage_idx), .busy(busy), .done(done), .aborted(aborted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {inlet, stage_en, outlet, stage_idx, busy, done, aborted, err}
  logic [11:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  string       cur_tag;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%03h expected=%03h (inlet,stage,outlet,idx,busy,done,abt,err)",
               tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {inlet_valve, stage_en, outlet_valve, stage_idx, busy, done, aborted, err};
  endfunction

  function automatic logic [11:0] mk(input logic [1:0] inl, input logic [1:0] stg,
                                     input logic [1:0] outl, input logic [1:0] idx,
                                     input logic b, input logic dn, input logic ab,
                                     input logic er);
    return {inl, stg, outl, idx, b, dn, ab, er};
  endfunction

  // Expected cycles of one run; abort_k (>=0) is the busy cycle during which abort is held.
  task automatic push_run(input logic [1:0] mask, input int abort_k);
    int k;
    bit cut;
    k   = 0;
    cut = 0;
    for (int i = 0; i < 2; i++) begin
      if (mask[i]) begin
        for (int c = 0; c < L; c++) begin
          if (!cut) begin
            exp_q.push_back(mk(2'(1 << i), 2'b00, 2'b00, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
            cut = (k == abort_k);
            k++;
          end
        end
      end
    end
    for (int s = 1; s >= 0; s--) begin
      for (int c = 0; c < M; c++) begin
        if (!cut) begin
          exp_q.push_back(mk(2'b00, 2'(1 << s), 2'b00, 2'(s), 1'b1, 1'b0, 1'b0, 1'b0));
          cut = (k == abort_k);
          k++;
        end
      end
    end
    for (int c = 0; c < D; c++) begin
      if (!cut) begin
        exp_q.push_back(mk(2'b00, 2'b00, mask, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        cut = (k == abort_k);
        k++;
      end
    end
    if (cut) begin
      for (int c = 0; c < D; c++)
        exp_q.push_back(mk(2'b00, 2'b00, 2'b11, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    end else begin
      exp_q.push_back(mk(2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    end
  endtask

  // One clock: compare the post-edge outputs with the next scoreboard entry (idle if empty).
  task automatic step();
    logic [11:0] e;
    @(posedge clk);
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
    check(cur_tag, obs(), e);
  endtask

  task automatic do_run(input string tag, input logic [1:0] mask, input int abort_k);
    int stepno;
    cur_tag = tag;
    push_run(mask, abort_k);
    in_mask = mask;
    start   = 1'b1;
    step();
    start  = 1'b0;
    stepno = 1;
    while (exp_q.size() > 0) begin
      abort = (abort_k >= 0 && stepno == abort_k + 1);
      step();
      stepno++;
    end
    abort = 1'b0;
    step();
    $display("[TB] %s mask=%b abort_k=%0d checked %0d cycles", tag, mask, abort_k, stepno + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stepno;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    in_mask = 2'b00;
    cur_tag = "reset";
    #12;
    check("reset", obs(), 12'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Abort is ignored while idle.
    cur_tag = "abort_idle";
    abort   = 1'b1;
    step();
    step();
    abort = 1'b0;

    do_run("full_mask11", 2'b11, -1);
    do_run("mask10", 2'b10, -1);
    do_run("mask01", 2'b01, -1);

    cur_tag = "err_mask0";
    exp_q.push_back(mk(2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(12'h000);
    in_mask = 2'b00;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    $display("[TB] err_mask0 checked 3 cycles");

    do_run("abort_mix2", 2'b11, 7);
    do_run("abort_load1", 2'b11, 1);
    do_run("abort_last_drain", 2'b01, 12);

    // Async reset in the middle of LOAD.
    cur_tag = "rst_midload";
    push_run(2'b11, -1);
    in_mask = 2'b11;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rst_async", obs(), 12'h000);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_hold", obs(), 12'h000);
    rst_n = 1'b1;
    step();
    $display("[TB] rst_midload async clear checked");
    do_run("after_rst", 2'b11, -1);

    // Start held through a run and its done cycle: back-to-back runs, mid-run mask ignored.
    cur_tag = "back2back";
    push_run(2'b11, -1);
    push_run(2'b11, -1);
    in_mask = 2'b11;
    start   = 1'b1;
    stepno  = 0;
    while (exp_q.size() > 0) begin
      step();
      stepno++;
      if (stepno == 3)  in_mask = 2'b01;
      if (stepno == 10) in_mask = 2'b11;
      if (stepno == 18) start = 1'b0;
    end
    step();
    step();
    $display("[TB] back2back checked %0d cycles", stepno + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
